i2c_txn_arbiter: RTL and testbench
==================================

Name: i2c_txn_arbiter

Overview:
- Shares the single `i2c_master` byte-level core between N_REQ independent requesters, e.g. LED refresh, jack poll and a user register-access port.
- Each requester posts one single-register transaction, either a write or a random read. The arbiter grants round-robin, expands the transaction into the START/WRITE/READ/STOP command stream, and returns read data and NACK status.
- Sits between the pmod I2C sequencing logic and the `i2c_master` instance.

Parameters:
- N_REQ, 3, number of requesters (2..8).
- RETRIES, 2, extra attempts after a NACK; used only with the optional feature.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req  in  N_REQ  per-requester transaction request, level
- rw  in  N_REQ  1 = read, 0 = write
- dev_addr  in  7*N_REQ  7-bit device address; requester i in bits [7i+6:7i]
- reg_addr  in  8*N_REQ  register index; requester i in bits [8i+7:8i]
- wdata  in  8*N_REQ  write byte; requester i in bits [8i+7:8i]
- done  out  N_REQ  one-cycle completion pulse to the granted requester
- nack  out  N_REQ  NACK status, valid with done
- rdata  out  8  read byte, valid with done on a read
- busy  out  1  transaction in progress
- grant_idx  out  $clog2(N_REQ)  index of the current or last grant
- cmd  out  2  to i2c_master: 00 START, 01 STOP, 10 WRITE, 11 READ
- data_in  out  8  to i2c_master: byte to write
- ack_in  out  1  to i2c_master: 1 = NACK on read
- stb  out  1  to i2c_master: command strobe
- data_out  in  8  from i2c_master: read byte
- ack_out  in  1  from i2c_master: 1 = slave NACKed
- ready  in  1  from i2c_master: core idle

Behaviour:
- Reset values: all outputs 0 (done, nack, rdata, busy, grant_idx, cmd, data_in, ack_in, stb). Round-robin pointer = 0. State = IDLE.
- Command handshake:
  - cmd, data_in and ack_in are set in the same cycle stb pulses high for exactly one cycle.
  - The next command is issued only in a cycle with ready=1 and stb=0.
  - data_out and ack_out are sampled at that point; they are the result of the previous command.
- Arbitration:
  - In IDLE with any req set, grant the first set req at or after rr_ptr, wrapping modulo N_REQ.
  - Latch that requester's rw/dev_addr/reg_addr/wdata into internal registers.
  - Set rr_ptr = grant+1 mod N_REQ, busy=1, update grant_idx.
  - Grant decision takes one cycle. Requests arriving mid-transaction wait.
- States: IDLE -> START -> ADDR_W -> REG -> (rw ? RESTART -> ADDR_R -> READ : WDATA) -> STOP -> DONE -> IDLE.
  - START and RESTART issue START.
  - ADDR_W writes {dev_addr,0}; ADDR_R writes {dev_addr,1}.
  - REG writes reg_addr; WDATA writes wdata.
  - READ issues READ with ack_in=1 (single byte, not acknowledged). ack_in=0 for all other commands.
- Command count: write = 5 commands, read = 7 commands.
- NACK handling: ack_out=1 sampled after ADDR_W, REG, WDATA or ADDR_R sets an internal nack flag. The arbiter skips directly to STOP.
- DONE state:
  - Pulse done[grant] for one cycle.
  - nack[grant] = flag; all other nack bits 0.
  - rdata = data_out captured after READ for reads; holds its previous value for writes or on NACK.
  - busy drops the cycle after done.
- req deasserted mid-transaction: ignored; the transaction completes and done still pulses.
- A requester holding req after done is eligible again, but only after the other pending requesters (round-robin fairness).
- Simultaneous all-req with rr_ptr=2, N_REQ=3: grant order is 2, 0, 1.
- rst mid-transaction returns to IDLE next cycle with stb=0. No STOP is issued; the shared rst also resets i2c_master.

Optional Feature:
- Macro I2C_TXN_ARBITER_RETRY_EN.
- When defined: on NACK, after STOP, the arbiter re-enters START for the same latched transaction, up to RETRIES extra attempts. nack reports only if the final attempt NACKs. The grant is held across retries.
- When undefined: no retry; the first NACK completes the transaction with nack=1, and RETRIES is unused.

Decomposition:
- Package i2c_arb_pkg:
  - cmd encodings I2C_CMD_START/STOP/WRITE/READ;
  - state enum txn_state_t;
  - constants ADDR_RD_BIT=1, ADDR_WR_BIT=0.
- Sub-module rr_arbiter: combinational round-robin pick from req and rr_ptr, producing gnt_valid and gnt_idx. The top-level block owns all sequencing.

Test Plan:
- Write: req[0], dev 0x18, reg 0x02, wdata 0x00, model ACKs -> stb sequence START, WR 0x30, WR 0x02, WR 0x00, STOP; done[0]=1, nack[0]=0.
- Read: req[1], dev 0x52, reg 0xFA, model returns 0xAB -> START, WR 0xA4, WR 0xFA, START, WR 0xA5, READ(ack_in=1), STOP; rdata=0xAB with done[1].
- Round-robin: req=3'b111 held, rr_ptr=0 -> done pulses in order 0, 1, 2, 0; no stb issued while ready=0.
- NACK: model NACKs the address byte -> next command is STOP, skipping REG; nack[2]=1. With RETRY_EN and RETRIES=2: 3 address attempts, then nack=1.
- Reset: assert rst during the REG command -> next cycle stb=0, busy=0, done=0. A new req afterwards completes normally.

Source files
------------

// File: rtl/i2c_arb_pkg.sv
// Shared definitions for the I2C transaction arbiter: i2c_master command
// encodings, address R/W bit values and the transaction FSM states.
package i2c_arb_pkg;

    localparam logic [1:0] I2C_CMD_START = 2'b00;
    localparam logic [1:0] I2C_CMD_STOP  = 2'b01;
    localparam logic [1:0] I2C_CMD_WRITE = 2'b10;
    localparam logic [1:0] I2C_CMD_READ  = 2'b11;

    localparam logic ADDR_RD_BIT = 1'b1;
    localparam logic ADDR_WR_BIT = 1'b0;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_ADDR_W,
        ST_REG,
        ST_RESTART,
        ST_ADDR_R,
        ST_READ,
        ST_WDATA,
        ST_STOP,
        ST_DONE
    } txn_state_t;

endpackage

// File: rtl/i2c_txn_arbiter_rr.sv
// Combinational round-robin pick: first set req at or after rr_ptr,
// wrapping modulo N_REQ.
module rr_arbiter #(
    parameter int N_REQ = 3,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic             gnt_valid,
    output logic [IDX_W-1:0] gnt_idx
);

    localparam logic [IDX_W:0] N_VAL = (IDX_W + 1)'(N_REQ);

    logic [2*N_REQ-1:0] req_dbl;
    logic [N_REQ-1:0]   req_rot;
    logic [IDX_W-1:0]   offset;
    logic [IDX_W:0]     sum;

    // Rotating the doubled vector puts the rr_ptr requester at bit 0.
    assign req_dbl = {req, req};
    assign req_rot = N_REQ'(req_dbl >> rr_ptr);

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        gnt_valid = 1'b0;
        offset    = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                gnt_valid = 1'b1;
                offset    = IDX_W'(i);
            end
        end
    end

    assign sum     = {1'b0, rr_ptr} + {1'b0, offset};
    assign gnt_idx = (sum >= N_VAL) ? IDX_W'(sum - N_VAL) : IDX_W'(sum);

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter sharing one i2c_master core between N_REQ requesters.
// Build macro I2C_TXN_ARBITER_RETRY_EN re-runs a NACKed transaction up to RETRIES times.
module i2c_txn_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int N_REQ   = 3,
    parameter int RETRIES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ-1:0]           rw,
    input  logic [7*N_REQ-1:0]         dev_addr,
    input  logic [8*N_REQ-1:0]         reg_addr,
    input  logic [8*N_REQ-1:0]         wdata,
    output logic [N_REQ-1:0]           done,
    output logic [N_REQ-1:0]           nack,
    output logic [7:0]                 rdata,
    output logic                       busy,
    output logic [$clog2(N_REQ)-1:0]   grant_idx,
    output logic [1:0]                 cmd,
    output logic [7:0]                 data_in,
    output logic                       ack_in,
    output logic                       stb,
    input  logic [7:0]                 data_out,
    input  logic                       ack_out,
    input  logic                       ready
);

    localparam int IDX_W  = $clog2(N_REQ);
    localparam int RCNT_W = $clog2(RETRIES + 2);

`ifdef I2C_TXN_ARBITER_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    txn_state_t        state, state_d;
    logic [IDX_W-1:0]  rr_ptr, rr_ptr_d, grant_d, gnt_idx;
    logic              gnt_valid, grant_now;
    logic              lat_rw;
    logic [6:0]        lat_dev;
    logic [7:0]        lat_reg, lat_wdata;
    logic              nack_flag, nack_flag_d, chk_ack, chk_ack_d, nack_now;
    logic [RCNT_W-1:0] retry_cnt, retry_cnt_d;
    logic              busy_d, stb_d, ack_in_d, can_issue;
    logic [1:0]        cmd_d, norm_cmd;
    logic [7:0]        data_in_d, rdata_d, norm_data;
    txn_state_t        norm_next;
    logic [N_REQ-1:0]  grant_onehot;

    rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_rr (
        .req       (req),
        .rr_ptr    (rr_ptr),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    assign grant_now = (state == ST_IDLE) && gnt_valid;
    assign can_issue = ready && !stb;
    // ack_out reflects the previous command; only address/register/data writes can NACK.
    assign nack_now  = chk_ack && ack_out;

    always_comb begin
        norm_cmd  = I2C_CMD_STOP;
        norm_data = 8'h00;
        norm_next = ST_DONE;
        case (state)
            ST_START:   begin norm_cmd = I2C_CMD_START; norm_next = ST_ADDR_W; end
            ST_RESTART: begin norm_cmd = I2C_CMD_START; norm_next = ST_ADDR_R; end
            ST_ADDR_W:  begin norm_cmd = I2C_CMD_WRITE; norm_data = {lat_dev, ADDR_WR_BIT}; norm_next = ST_REG; end
            ST_REG:     begin norm_cmd = I2C_CMD_WRITE; norm_data = lat_reg; norm_next = lat_rw ? ST_RESTART : ST_WDATA; end
            ST_WDATA:   begin norm_cmd = I2C_CMD_WRITE; norm_data = lat_wdata; norm_next = ST_STOP; end
            ST_ADDR_R:  begin norm_cmd = I2C_CMD_WRITE; norm_data = {lat_dev, ADDR_RD_BIT}; norm_next = ST_READ; end
            ST_READ:    begin norm_cmd = I2C_CMD_READ;  norm_next = ST_STOP; end
            default:    ;
        endcase
    end

    always_comb begin
        state_d     = state;
        rr_ptr_d    = rr_ptr;
        grant_d     = grant_idx;
        nack_flag_d = nack_flag;
        chk_ack_d   = chk_ack;
        retry_cnt_d = retry_cnt;
        busy_d      = busy;
        stb_d       = 1'b0;
        cmd_d       = cmd;
        data_in_d   = data_in;
        ack_in_d    = ack_in;
        rdata_d     = rdata;

        case (state)
            ST_IDLE: begin
                if (gnt_valid) begin
                    grant_d     = gnt_idx;
                    rr_ptr_d    = (gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
                    busy_d      = 1'b1;
                    nack_flag_d = 1'b0;
                    chk_ack_d   = 1'b0;
                    retry_cnt_d = RCNT_W'(RETRIES);
                    state_d     = ST_START;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                if (can_issue) begin
                    stb_d     = 1'b1;
                    chk_ack_d = 1'b0;
                    if (nack_now || state == ST_STOP) begin
                        cmd_d     = I2C_CMD_STOP;
                        data_in_d = 8'h00;
                        ack_in_d  = 1'b0;
                        // STOP is only reached from READ on the read path, so data_out is the read byte.
                        if (state == ST_STOP && lat_rw) rdata_d = data_out;
                        if (nack_now && RETRY_EN && retry_cnt != '0) begin
                            retry_cnt_d = retry_cnt - RCNT_W'(1);
                            state_d     = ST_START;
                        end else begin
                            nack_flag_d = nack_now;
                            state_d     = ST_DONE;
                        end
                    end else begin
                        cmd_d     = norm_cmd;
                        data_in_d = norm_data;
                        ack_in_d  = (norm_cmd == I2C_CMD_READ);
                        chk_ack_d = (norm_cmd == I2C_CMD_WRITE);
                        state_d   = norm_next;
                    end
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            grant_idx <= '0;
            nack_flag <= 1'b0;
            chk_ack   <= 1'b0;
            retry_cnt <= '0;
            busy      <= 1'b0;
            stb       <= 1'b0;
            cmd       <= 2'b00;
            data_in   <= 8'h00;
            ack_in    <= 1'b0;
            rdata     <= 8'h00;
        end else begin
            state     <= state_d;
            rr_ptr    <= rr_ptr_d;
            grant_idx <= grant_d;
            nack_flag <= nack_flag_d;
            chk_ack   <= chk_ack_d;
            retry_cnt <= retry_cnt_d;
            busy      <= busy_d;
            stb       <= stb_d;
            cmd       <= cmd_d;
            data_in   <= data_in_d;
            ack_in    <= ack_in_d;
            rdata     <= rdata_d;
        end
    end

    // NOTE: the latched transaction fields are loaded at every grant before use, so they need no reset.
    always_ff @(posedge clk) begin
        if (grant_now) begin
            lat_rw    <= rw[gnt_idx];
            lat_dev   <= 7'(dev_addr >> (7 * gnt_idx));
            lat_reg   <= 8'(reg_addr >> (8 * gnt_idx));
            lat_wdata <= 8'(wdata >> (8 * gnt_idx));
        end
    end

    assign grant_onehot = N_REQ'(1) << grant_idx;
    assign done = (state == ST_DONE) ? grant_onehot : '0;
    assign nack = (state == ST_DONE && nack_flag) ? grant_onehot : '0;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Self-checking bench for i2c_txn_arbiter: an i2c_master/slave bus model plus a
// transaction-level reference model (expected command list, nack, rdata, grant order).
module tb_i2c_txn_arbiter;
    import i2c_arb_pkg::*;

    localparam int N_REQ   = 3;
    localparam int RETRIES = 2;
    localparam int IW      = $clog2(N_REQ);
`ifdef I2C_TXN_ARBITER_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    typedef struct packed {
        logic [1:0] c;
        logic       a;
        logic [7:0] d;
    } cmd_rec_t;

    logic               clk, rst;
    logic [N_REQ-1:0]   req, rw, done, nack;
    logic [7*N_REQ-1:0] dev_addr;
    logic [8*N_REQ-1:0] reg_addr, wdata;
    logic [7:0]         rdata, data_in, data_out;
    logic               busy, ack_in, stb, ack_out, ready;
    logic [IW-1:0]      grant_idx;
    logic [1:0]         cmd;

    i2c_txn_arbiter #(.N_REQ(N_REQ), .RETRIES(RETRIES)) dut (
        .clk(clk), .rst(rst), .req(req), .rw(rw), .dev_addr(dev_addr),
        .reg_addr(reg_addr), .wdata(wdata), .done(done), .nack(nack),
        .rdata(rdata), .busy(busy), .grant_idx(grant_idx), .cmd(cmd),
        .data_in(data_in), .ack_in(ack_in), .stb(stb), .data_out(data_out),
        .ack_out(ack_out), .ready(ready)
    );

    int checks = 0;
    int errors = 0;
    cmd_rec_t log_q[$], exp_q[$], last_log[$];
    bit         stall = 0;
    int         model_ptr = 0;
    logic [7:0] exp_rdata = 8'h00;
    logic       rw_f[N_REQ];
    logic [6:0] dev_f[N_REQ];
    logic [7:0] reg_f[N_REQ], wd_f[N_REQ];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic cmd_rec_t rec(input logic [1:0] c, input logic a, input logic [7:0] d);
        cmd_rec_t r;
        r.c = c; r.a = a; r.d = d;
        return r;
    endfunction

    // Slave population: addresses 0x70..0x7F are absent; byte 0xEE is refused.
    function automatic logic [7:0] slave_rd(input logic [6:0] dev, input logic [7:0] rg);
        if (dev == 7'h52 && rg == 8'hFA) return 8'hAB;
        return {1'b0, dev} ^ rg ^ 8'h5A;
    endfunction

    // i2c_master + slave bus model: logs every strobed command and answers after a random delay.
    initial begin : bfm
        int         wait_cnt;
        int         wr_idx;
        logic [6:0] cur_dev;
        logic [7:0] cur_reg, resp_data;
        logic       resp_ack;
        wait_cnt = 0; wr_idx = 0; cur_dev = '0; cur_reg = '0; resp_data = '0; resp_ack = 0;
        ready = 1'b1; data_out = 8'h00; ack_out = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                ready = 1'b1; wait_cnt = 0;
            end else if (stb) begin
                check("ready_at_stb", {31'd0, ready}, 32'd1);
                log_q.push_back(rec(cmd, ack_in, (cmd == I2C_CMD_WRITE) ? data_in : 8'h00));
                resp_ack  = 1'b0;
                resp_data = 8'($urandom);
                case (cmd)
                    I2C_CMD_START: wr_idx = 0;
                    I2C_CMD_WRITE: begin
                        if (wr_idx == 0) begin
                            cur_dev  = data_in[7:1];
                            resp_ack = (data_in[7:1] >= 7'h70);
                        end else begin
                            if (wr_idx == 1) cur_reg = data_in;
                            resp_ack = (data_in == 8'hEE);
                        end
                        wr_idx++;
                    end
                    I2C_CMD_READ: resp_data = slave_rd(cur_dev, cur_reg);
                    default: ;
                endcase
                ready    = 1'b0;
                wait_cnt = $urandom_range(1, 4);
            end else if (!ready) begin
                if (wait_cnt > 0) wait_cnt--;
                if (wait_cnt == 0 && !stall) begin
                    ready = 1'b1; ack_out = resp_ack; data_out = resp_data;
                end
            end
        end
    end

    // Reference: expected command list and outcome of one posted transaction.
    task automatic model_txn(input logic r, input logic [6:0] dev, input logic [7:0] rg,
                             input logic [7:0] wd, output bit nk);
        int  attempts;
        bit  fail;
        exp_q.delete();
        attempts = RETRY_EN ? RETRIES + 1 : 1;
        fail = 0;
        for (int a = 0; a < attempts; a++) begin
            fail = 0;
            exp_q.push_back(rec(I2C_CMD_START, 1'b0, 8'h00));
            exp_q.push_back(rec(I2C_CMD_WRITE, 1'b0, {dev, 1'b0}));
            if (dev >= 7'h70) fail = 1;
            else begin
                exp_q.push_back(rec(I2C_CMD_WRITE, 1'b0, rg));
                if (rg == 8'hEE) fail = 1;
                else if (!r) begin
                    exp_q.push_back(rec(I2C_CMD_WRITE, 1'b0, wd));
                    if (wd == 8'hEE) fail = 1;
                end else begin
                    exp_q.push_back(rec(I2C_CMD_START, 1'b0, 8'h00));
                    exp_q.push_back(rec(I2C_CMD_WRITE, 1'b0, {dev, 1'b1}));
                    exp_q.push_back(rec(I2C_CMD_READ, 1'b1, 8'h00));
                end
            end
            exp_q.push_back(rec(I2C_CMD_STOP, 1'b0, 8'h00));
            if (!fail) break;
        end
        nk = fail;
        if (!fail && r) exp_rdata = slave_rd(dev, rg);
    endtask

    function automatic int rr_pick(input logic [N_REQ-1:0] m, input int ptr);
        for (int i = 0; i < N_REQ; i++) begin
            if (m[(ptr + i) % N_REQ]) return (ptr + i) % N_REQ;
        end
        return -1;
    endfunction

    task automatic set_fields(input int i, input logic r, input logic [6:0] d,
                              input logic [7:0] g, input logic [7:0] w);
        rw_f[i] = r; dev_f[i] = d; reg_f[i] = g; wd_f[i] = w;
        rw[i] = r;
        dev_addr[7*i +: 7] = d;
        reg_addr[8*i +: 8] = g;
        wdata[8*i +: 8]    = w;
    endtask

    task automatic await_done(output int idx);
        idx = -1;
        for (int c = 0; c < 2000; c++) begin
            tick();
            if (done != '0) begin
                for (int i = N_REQ - 1; i >= 0; i--) if (done[i]) idx = i;
                break;
            end
        end
        if (idx < 0) begin
            checks++; errors++;
            $error("FAIL done_timeout: observed no done within 2000 cycles, expected a done pulse");
        end
    endtask

    task automatic check_txn(input int exp_idx, input logic [N_REQ-1:0] clr);
        int               idx, n;
        bit               nk;
        logic [N_REQ-1:0] exp_vec;
        await_done(idx);
        if (idx < 0) begin
            req = req & ~clr;
            return;
        end
        exp_vec = N_REQ'(1) << exp_idx;
        model_txn(rw_f[exp_idx], dev_f[exp_idx], reg_f[exp_idx], wd_f[exp_idx], nk);
        check("done_vec", 32'(done), 32'(exp_vec));
        check("grant_idx", 32'(grant_idx), 32'(exp_idx));
        check("nack_vec", 32'(nack), nk ? 32'(exp_vec) : 32'd0);
        check("rdata", 32'(rdata), 32'(exp_rdata));
        check("cmd_count", 32'(log_q.size()), 32'(exp_q.size()));
        n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("cmd_seq[%0d]", i), 32'(log_q[i]), 32'(exp_q[i]));
        last_log = log_q;
        log_q.delete();
        req = req & ~clr;
        model_ptr = (exp_idx + 1) % N_REQ;
        tick();
        check("done_width", 32'(done), 32'd0);
        check("busy_after_done", {31'd0, busy}, 32'd0);
    endtask

    task automatic do_reset(input bit check_outputs);
        rst = 1'b1;
        req = '0;
        repeat (3) tick();
        if (check_outputs) begin
            check("rst_done", 32'(done), 0);
            check("rst_nack", 32'(nack), 0);
            check("rst_rdata", 32'(rdata), 0);
            check("rst_busy", {31'd0, busy}, 0);
            check("rst_grant_idx", 32'(grant_idx), 0);
            check("rst_cmd", 32'(cmd), 0);
            check("rst_data_in", 32'(data_in), 0);
            check("rst_ack_in", {31'd0, ack_in}, 0);
            check("rst_stb", {31'd0, stb}, 0);
        end
        rst = 1'b0;
        log_q.delete();
        model_ptr = 0;
        exp_rdata = 8'h00;
    endtask

    initial begin : stimulus
        int c, stb_seen, pick;
        logic [N_REQ-1:0] pend;
        rst = 1'b1; req = '0; rw = '0; dev_addr = '0; reg_addr = '0; wdata = '0;
        for (int i = 0; i < N_REQ; i++) set_fields(i, 1'b0, 7'h10, 8'h00, 8'h00);
        do_reset(1'b1);

        // Directed write from requester 0.
        set_fields(0, 1'b0, 7'h18, 8'h02, 8'h00);
        req = 3'b001;
        check_txn(0, 3'b001);
        check("wr_len", 32'(last_log.size()), 32'd5);
        if (last_log.size() > 1) check("wr_addr_byte", 32'(last_log[1].d), 32'h30);

        // Directed read from requester 1; req dropped mid-transaction and the core stalled.
        set_fields(1, 1'b1, 7'h52, 8'hFA, 8'h00);
        req = 3'b010;
        for (c = 0; c < 200 && !busy; c++) tick();
        check("busy_on_grant", {31'd0, busy}, 32'd1);
        req = 3'b000;
        for (c = 0; c < 200 && log_q.size() < 2; c++) tick();
        stall = 1;
        repeat (6) tick();
        stb_seen = 0;
        repeat (20) begin
            tick();
            if (stb) stb_seen++;
        end
        check("stb_while_not_ready", 32'(stb_seen), 32'd0);
        stall = 0;
        check_txn(1, 3'b000);
        check("rd_len", 32'(last_log.size()), 32'd7);
        check("rd_rdata", 32'(rdata), 32'hAB);
        if (last_log.size() > 4) check("rd_addr_byte", 32'(last_log[4].d), 32'hA5);

        // Round robin with all requests held from rr_ptr=0.
        do_reset(1'b0);
        set_fields(0, 1'b0, 7'h20, 8'h11, 8'h22);
        set_fields(1, 1'b1, 7'h21, 8'h33, 8'h00);
        set_fields(2, 1'b0, 7'h22, 8'h44, 8'h55);
        req = 3'b111;
        check_txn(0, 3'b000);
        check_txn(1, 3'b000);
        check_txn(2, 3'b000);
        check_txn(0, 3'b111);

        // rr_ptr=2 with simultaneous requests: order 2, 0, 1.
        do_reset(1'b0);
        req = 3'b010;
        check_txn(1, 3'b010);
        req = 3'b111;
        check_txn(2, 3'b100);
        check_txn(0, 3'b001);
        check_txn(1, 3'b010);

        // Address NACK: STOP follows the address byte directly.
        set_fields(2, 1'b0, 7'h7A, 8'h05, 8'h06);
        req = 3'b100;
        check_txn(2, 3'b100);
        check("nack_len", 32'(last_log.size()), RETRY_EN ? 32'd9 : 32'd3);
        if (last_log.size() > 2) check("nack_then_stop", 32'(last_log[2].c), 32'(I2C_CMD_STOP));

        // Reset during the REG command.
        set_fields(0, 1'b0, 7'h18, 8'h02, 8'h77);
        req = 3'b001;
        for (c = 0; c < 500 && log_q.size() < 3; c++) tick();
        check("reg_cmd_reached", 32'(log_q.size()), 32'd3);
        rst = 1'b1;
        tick();
        check("mid_rst_stb", {31'd0, stb}, 0);
        check("mid_rst_busy", {31'd0, busy}, 0);
        check("mid_rst_done", 32'(done), 0);
        rst = 1'b0;
        log_q.delete();
        model_ptr = 0;
        exp_rdata = 8'h00;
        check_txn(0, 3'b001);

        // Randomized rounds against the reference model.
        for (int round = 0; round < 12; round++) begin
            for (int i = 0; i < N_REQ; i++)
                set_fields(i, 1'($urandom),
                           ($urandom_range(0, 5) == 0) ? 7'(7'h70 + $urandom_range(0, 15)) : 7'($urandom_range(0, 7'h6F)),
                           ($urandom_range(0, 7) == 0) ? 8'hEE : 8'($urandom),
                           ($urandom_range(0, 7) == 0) ? 8'hEE : 8'($urandom));
            pend = N_REQ'($urandom_range(1, (1 << N_REQ) - 1));
            req = pend;
            while (pend != '0) begin
                pick = rr_pick(pend, model_ptr);
                check_txn(pick, N_REQ'(1) << pick);
                pend[pick] = 1'b0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
